serial_adder: RTL and testbench

- Bit-serial ripple adder that consumes one sum/carry bit per clock from a single full-adder cell built from two half_adder instances.
- Loads two WIDTH-bit operands on start, processes them LSB-first over WIDTH cycles, and presents the registered sum and carry-out with a one-cycle done pulse.
- Sits directly downstream of half_adder: it is the sequential datapath that uses the half-adder pair and a carry flop to form a multi-bit adder.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/full_adder.sv | 31 +++
 rtl/half_adder.sv | 12 +
 rtl/serial_adder.sv | 90 +++++++++
 tb/tb_serial_adder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings and sizing helpers for serial_adder
package serial_adder_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width: must hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - full adder cell built from two half adders
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s0),
        .carry (c0)
    );

    half_adder u_ha1 (
        .a     (s0),
        .b     (cin),
        .sum   (sum),
        .carry (c1)
    );

    // At most one of the two half-adder carries can be set, so OR forms the cell carry.
    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - single-bit half adder
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with registered sum/carry and done pulse
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             cflop;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (cflop),
        .sum  (fa_s),
        .cout (fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
    assign acc_next = (acc >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

    // Control FSM plus operand/accumulator shifting; outputs only load on the last bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            cnt   <= '0;
            cflop <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        cflop <= 1'b0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc   <= acc_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cflop <= fa_co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        sum   <= acc_next;
                        carry <= fa_co;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       carry1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .carry (carry1)
    );

    // Called #1 after an edge; runs one add on the 8-bit DUT and returns what it observed.
    task automatic run_add8(input logic [7:0] ia, input logic [7:0] ib,
                            output logic [7:0] rs, output logic rc,
                            output int nbusy, output int ndone, output int dat);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nbusy = 0; ndone = 0; dat = -1; rs = 'x; rc = 1'bx;
        for (int i = 0; i < 14; i++) begin
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin
                ndone++; dat = i; rs = sum; rc = carry;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b sum=%h carry=%b expected 0 0 00 0", busy, done, sum, carry);
        end
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 1'b0 || carry1 !== 1'b0) begin
            errors++;
            $display("FAIL reset1: busy=%b done=%b sum=%b carry=%b expected 0 0 0 0", busy1, done1, sum1, carry1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [7:0] rs; logic rc; int nb, nd, dat;
        run_add8(8'h35, 8'h4A, rs, rc, nb, nd, dat);
        checks++;
        if (nb !== 8 || nd !== 1 || dat !== 8) begin
            errors++;
            $display("FAIL basic_timing: busy_cycles=%0d done_pulses=%0d done_at=%0d expected 8 1 8", nb, nd, dat);
        end
        checks++;
        if (rs !== 8'h7F || rc !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum: sum=%h carry=%b expected 7f 0", rs, rc);
        end
    endtask

    task automatic test_ripple_hold;
        logic [7:0] rs; logic rc; int nb, nd, dat;
        run_add8(8'hFF, 8'h01, rs, rc, nb, nd, dat);
        checks++;
        if (rs !== 8'h00 || rc !== 1'b1 || nd !== 1) begin
            errors++;
            $display("FAIL ripple: sum=%h carry=%b pulses=%0d expected 00 1 1", rs, rc, nd);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sum !== 8'h00 || carry !== 1'b1) begin
            errors++;
            $display("FAIL ripple_hold: sum=%h carry=%b expected 00 1", sum, carry);
        end
    endtask

    task automatic test_start_held;
        logic [7:0] rs; logic rc; int nd, nb, dat;
        a = 8'h10; b = 8'h20; start = 1'b1;
        @(posedge clk); #1;
        nd = 0; rs = 'x; rc = 1'bx;
        for (int i = 0; i < 10; i++) begin
            a = 8'hC3 ^ 8'(i * 17); b = 8'h5A + 8'(i);
            start = (i < 9);
            if (done === 1'b1) begin
                nd++; rs = sum; rc = carry;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (rs !== 8'h30 || rc !== 1'b0 || nd !== 1) begin
            errors++;
            $display("FAIL start_held: sum=%h carry=%b pulses=%0d expected 30 0 1", rs, rc, nd);
        end
        run_add8(8'h01, 8'h02, rs, rc, nb, nd, dat);
        checks++;
        if (rs !== 8'h03 || rc !== 1'b0 || nd !== 1 || dat !== 8) begin
            errors++;
            $display("FAIL start_after_held: sum=%h carry=%b pulses=%0d done_at=%0d expected 03 0 1 8", rs, rc, nd, dat);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] rs; logic rc; int nb, nd, dat;
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h carry=%b expected 0 0 00 0", busy, done, sum, carry);
        end
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) nd++;
            @(posedge clk); #1;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: active_cycles=%0d expected 0", nd);
        end
        run_add8(8'h80, 8'h80, rs, rc, nb, nd, dat);
        checks++;
        if (rs !== 8'h00 || rc !== 1'b1 || nd !== 1) begin
            errors++;
            $display("FAIL after_reset_add: sum=%h carry=%b pulses=%0d expected 00 1 1", rs, rc, nd);
        end
    endtask

    task automatic test_carry_clear;
        logic rc_mid; logic [7:0] rs; logic rc; int nd;
        a = 8'h00; b = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nd = 0; rs = 'x; rc = 1'bx; rc_mid = 1'bx;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) rc_mid = carry;
            if (done === 1'b1) begin
                nd++; rs = sum; rc = carry;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rc_mid !== 1'b1) begin
            errors++;
            $display("FAIL carry_hold_in_shift: carry=%b expected 1", rc_mid);
        end
        checks++;
        if (rs !== 8'h00 || rc !== 1'b0 || nd !== 1) begin
            errors++;
            $display("FAIL carry_clear: sum=%h carry=%b pulses=%0d expected 00 0 1", rs, rc, nd);
        end
    endtask

    task automatic test_width1;
        logic [3:0] exp_s;
        logic [3:0] exp_c;
        int dat;
        logic rs, rc;
        exp_s = 4'b0110;
        exp_c = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            a1 = 1'(k & 1); b1 = 1'(k >> 1); start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            dat = -1; rs = 1'bx; rc = 1'bx;
            for (int i = 0; i < 5; i++) begin
                if (done1 === 1'b1 && dat < 0) begin
                    dat = i; rs = sum1[0]; rc = carry1;
                end
                @(posedge clk); #1;
            end
            checks++;
            if (dat !== 1 || rs !== exp_s[k] || rc !== exp_c[k]) begin
                errors++;
                $display("FAIL width1_%0d: done_at=%0d sum=%b carry=%b expected 1 %b %b", k, dat, rs, rc, exp_s[k], exp_c[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple_hold();
        test_start_held();
        test_reset_mid();
        test_carry_clear();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
